// File: rtl/urisc_pkg.sv
// Shared uRISC fetch-stage types and constants.
package urisc_pkg;

    localparam logic [15:0] NOP_INST           = 16'h0800;
    localparam logic [15:0] HALT_INST          = 16'h0000;
    localparam logic [15:0] DEFAULT_EXC_VECTOR = 16'h0002;

    typedef enum logic [1:0] {
        RUN,
        BUBBLE,
        HALTED
    } fetch_state_t;

    // One IF/ID slot: the instruction, its PC+2 and whether it is real.
    typedef struct packed {
        logic [15:0] inst;
        logic [15:0] pc_p1;
        logic        valid;
    } fetch_entry_t;

    // Invalid slot that keeps the last pc_p1 so the PC tag never goes stale-random.
    function automatic fetch_entry_t nop_entry(input logic [15:0] pc);
        fetch_entry_t e;
        e.inst  = NOP_INST;
        e.pc_p1 = pc;
        e.valid = 1'b0;
        return e;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding memory data that returns while decode stalls.
module fetch_skid_buf
    import urisc_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic         full
);

    fetch_entry_t entry_q;
    logic         full_q;

    // Flush beats push beats pop; push and pop never coincide in the fetch stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entry_q <= nop_entry(16'h0000);
            full_q  <= 1'b0;
        end else if (flush) begin
            full_q  <= 1'b0;
        end else if (push) begin
            entry_q <= din;
            full_q  <= 1'b1;
        end else if (pop) begin
            full_q  <= 1'b0;
        end
    end

    assign dout = entry_q;
    assign full = full_q;

endmodule

// File: rtl/fetch.sv
// uRISC instruction-fetch stage: owns the PC, the synchronous imem port and IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/bubble counters.
module fetch
    import urisc_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [15:0] EXC_VECTOR = DEFAULT_EXC_VECTOR,
    parameter int unsigned INST_BYTES = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] imem_addr_p1,
    output logic        imem_req_p1,
    input  logic [15:0] imem_rdata_p2,
    output logic [15:0] pc_p1,
    output logic [15:0] epc_p1,
    output logic [15:0] inst_ifid_p2,
    output logic        inst_valid_ifid_p2,
    input  logic        stall_idif_p3,
    input  logic        halt_idif_p3,
    input  logic        illegal_op_idif_p3,
    input  logic        return_execution_idif_p3,
    input  logic        jmp_displacement_idif_p3,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o,
`endif
    input  logic [15:0] jmp_displacement_value_idif_p3
);

    localparam logic [15:0] PC_STEP = 16'(INST_BYTES);

    fetch_state_t state_q, state_d;
    logic [15:0]  fetch_pc_q, fetch_pc_d;
    logic [15:0]  epc_q, epc_d;
    fetch_entry_t ifid_q, ifid_d;
    logic         live_q;
    logic         inflight_q, inflight_d;
    logic [15:0]  inflight_pc_q;

    logic         redirect;
    logic         arrive;
    logic         req;
    logic         skid_push, skid_pop, skid_flush, skid_full;
    fetch_entry_t skid_dout;
    fetch_entry_t arrive_entry;

    assign redirect = ifid_q.valid && (halt_idif_p3 || illegal_op_idif_p3 ||
                                       return_execution_idif_p3 || jmp_displacement_idif_p3);
    // Data on imem_rdata_p2 is ours only if last cycle's request survived.
    assign arrive   = inflight_q && (state_q == RUN);
    // A request issued while stalled with data already returning would have nowhere to land.
    assign req      = live_q && (state_q != HALTED) && !skid_full &&
                      !(stall_idif_p3 && arrive);

    assign arrive_entry = '{inst: imem_rdata_p2, pc_p1: inflight_pc_q, valid: 1'b1};

    fetch_skid_buf u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (skid_push),
        .pop   (skid_pop),
        .flush (skid_flush),
        .din   (arrive_entry),
        .dout  (skid_dout),
        .full  (skid_full)
    );

    // Next-state: redirect priority, stall/skid handling and sequential PC advance.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        epc_d      = epc_q;
        ifid_d     = ifid_q;
        inflight_d = req;
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        skid_flush = 1'b0;

        if (req) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        case (state_q)
            RUN: begin
                if (redirect) begin
                    // The request issued this cycle is wrong-path; forget it.
                    skid_flush = 1'b1;
                    inflight_d = 1'b0;
                    ifid_d     = nop_entry(ifid_q.pc_p1);
                    state_d    = BUBBLE;
                    if (halt_idif_p3) begin
                        state_d    = HALTED;
                        fetch_pc_d = fetch_pc_q;
                    end else if (illegal_op_idif_p3) begin
                        epc_d      = ifid_q.pc_p1;
                        fetch_pc_d = EXC_VECTOR;
                    end else if (return_execution_idif_p3) begin
                        fetch_pc_d = epc_q;
                    end else begin
                        fetch_pc_d = jmp_displacement_value_idif_p3;
                    end
                end else if (stall_idif_p3) begin
                    skid_push = arrive;
                end else if (skid_full) begin
                    skid_pop = 1'b1;
                    ifid_d   = skid_dout;
                end else if (arrive) begin
                    ifid_d = arrive_entry;
                end else begin
                    ifid_d = nop_entry(ifid_q.pc_p1);
                end
            end
            BUBBLE: begin
                state_d = RUN;
                ifid_d  = nop_entry(ifid_q.pc_p1);
            end
            HALTED: begin
                ifid_d = nop_entry(ifid_q.pc_p1);
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Pipeline state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            fetch_pc_q    <= RESET_PC;
            epc_q         <= 16'h0000;
            ifid_q        <= nop_entry(RESET_PC);
            live_q        <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            epc_q         <= epc_d;
            ifid_q        <= ifid_d;
            live_q        <= 1'b1;
            inflight_q    <= inflight_d;
            inflight_pc_q <= fetch_pc_q + PC_STEP;
        end
    end

    assign imem_addr_p1       = fetch_pc_q;
    assign imem_req_p1        = req;
    assign pc_p1              = ifid_q.pc_p1;
    assign epc_p1             = epc_q;
    assign inst_ifid_p2       = ifid_q.inst;
    assign inst_valid_ifid_p2 = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
    logic        load_valid;
    logic        bubble;
    logic [31:0] fetch_cnt_q, bubble_cnt_q;

    assign load_valid = (state_q == RUN) && !redirect && !stall_idif_p3 &&
                        (skid_full || arrive);
    assign bubble     = !ifid_q.valid && (state_q != HALTED);

    // Saturating performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q  <= 32'h0;
            bubble_cnt_q <= 32'h0;
        end else begin
            if (load_valid && (fetch_cnt_q != '1)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bubble && (bubble_cnt_q != '1)) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = fetch_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: instruction-stream model plus directed literal checks.
module tb_fetch;
    import urisc_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr_p1;
    logic        imem_req_p1;
    logic [15:0] imem_rdata_p2;
    logic [15:0] pc_p1;
    logic [15:0] epc_p1;
    logic [15:0] inst_ifid_p2;
    logic        inst_valid_ifid_p2;
    logic        stall_idif_p3;
    logic        halt_idif_p3;
    logic        illegal_op_idif_p3;
    logic        return_execution_idif_p3;
    logic        jmp_displacement_idif_p3;
    logic [15:0] jmp_displacement_value_idif_p3;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    fetch dut (
        .clk                            (clk),
        .rst                            (rst),
        .imem_addr_p1                   (imem_addr_p1),
        .imem_req_p1                    (imem_req_p1),
        .imem_rdata_p2                  (imem_rdata_p2),
        .pc_p1                          (pc_p1),
        .epc_p1                         (epc_p1),
        .inst_ifid_p2                   (inst_ifid_p2),
        .inst_valid_ifid_p2             (inst_valid_ifid_p2),
        .stall_idif_p3                  (stall_idif_p3),
        .halt_idif_p3                   (halt_idif_p3),
        .illegal_op_idif_p3             (illegal_op_idif_p3),
        .return_execution_idif_p3       (return_execution_idif_p3),
        .jmp_displacement_idif_p3       (jmp_displacement_idif_p3),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o                    (fetch_cnt_o),
        .bubble_cnt_o                   (bubble_cnt_o),
`endif
        .jmp_displacement_value_idif_p3 (jmp_displacement_value_idif_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: three fixed words at 0..4, an address-derived pattern elsewhere.
    function automatic logic [15:0] inst_at(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h481F;
            16'h0002: return 16'hA81F;
            16'h0004: return 16'h8810;
            default:  return {4'h6, a[12:1]};
        endcase
    endfunction

    // Synchronous memory: data one cycle after the request, garbage otherwise.
    always @(posedge clk) begin
        imem_rdata_p2 <= imem_req_p1 ? inst_at(imem_addr_p1) : 16'hDEAD;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!inst_valid_ifid_p2 && n < 20) begin
            tick();
            n++;
        end
        if (!inst_valid_ifid_p2) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for valid instruction actual=0 expected=1", tag);
        end
    endtask

    // Architectural model: the next instruction decode must see, its epc, and redirect gaps.
    logic [15:0] exp_pc;
    logic [15:0] exp_epc;
    logic [15:0] exp_pc2;
    logic        m_halted;
    logic        gap_on;
    int          gap;
    logic        redir_in;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] m_fetch;
    logic [31:0] m_bubble;
    logic        prev_hold;
`endif

    always @(negedge clk) begin
        if (!rst) begin
            exp_pc   = 16'h0000;
            exp_epc  = 16'h0000;
            m_halted = 1'b0;
            gap_on   = 1'b0;
            gap      = 0;
`ifdef FETCH_PERF_CNT_EN
            m_fetch   = 32'h0;
            m_bubble  = 32'h0;
            prev_hold = 1'b0;
`endif
        end else begin
            redir_in = halt_idif_p3 | illegal_op_idif_p3 | return_execution_idif_p3 |
                       jmp_displacement_idif_p3;
            check("model_epc", epc_p1, exp_epc);
            if (!inst_valid_ifid_p2) check("model_nop_when_invalid", inst_ifid_p2, NOP_INST);
            if (m_halted) begin
                check("model_halted_req", 16'(imem_req_p1), 16'h0);
                check("model_halted_valid", 16'(inst_valid_ifid_p2), 16'h0);
            end
`ifdef FETCH_PERF_CNT_EN
            if (inst_valid_ifid_p2 && !prev_hold) m_fetch = m_fetch + 32'd1;
            checks++;
            if (fetch_cnt_o !== m_fetch || bubble_cnt_o !== m_bubble) begin
                errors++;
                $display("FAIL model_counters actual=%h/%h expected=%h/%h",
                         fetch_cnt_o, bubble_cnt_o, m_fetch, m_bubble);
            end
            if (!inst_valid_ifid_p2 && !m_halted) m_bubble = m_bubble + 32'd1;
            prev_hold = inst_valid_ifid_p2 && stall_idif_p3 && !redir_in;
`endif
            if (inst_valid_ifid_p2) begin
                exp_pc2 = exp_pc + 16'd2;
                check("model_stream_inst", inst_ifid_p2, inst_at(exp_pc));
                check("model_stream_pc", pc_p1, exp_pc2);
                if (gap_on) begin
                    check("model_redirect_gap", 16'(gap), 16'd2);
                    gap_on = 1'b0;
                end
                if (redir_in) begin
                    gap_on = !halt_idif_p3;
                    gap    = 0;
                    if (halt_idif_p3) begin
                        m_halted = 1'b1;
                    end else if (illegal_op_idif_p3) begin
                        exp_epc = exp_pc2;
                        exp_pc  = 16'h0002;
                    end else if (return_execution_idif_p3) begin
                        exp_pc = exp_epc;
                    end else begin
                        exp_pc = jmp_displacement_value_idif_p3;
                    end
                end else if (!stall_idif_p3) begin
                    exp_pc = exp_pc2;
                end
            end else if (gap_on) begin
                gap++;
            end
        end
    end

    initial begin
        rst                            = 1'b0;
        stall_idif_p3                  = 1'b0;
        halt_idif_p3                   = 1'b0;
        illegal_op_idif_p3             = 1'b0;
        return_execution_idif_p3       = 1'b0;
        jmp_displacement_idif_p3       = 1'b0;
        jmp_displacement_value_idif_p3 = 16'h0000;

        repeat (3) @(posedge clk);
        #1;
        check("reset_req", 16'(imem_req_p1), 16'h0);
        check("reset_valid", 16'(inst_valid_ifid_p2), 16'h0);
        check("reset_inst", inst_ifid_p2, 16'h0800);
        check("reset_pc_p1", pc_p1, 16'h0000);
        check("reset_epc", epc_p1, 16'h0000);
        check("reset_addr", imem_addr_p1, 16'h0000);
        rst = 1'b1;

        // Straight-line fetch after reset.
        wait_valid("t1");
        check("t1_inst0", inst_ifid_p2, 16'h481F);
        check("t1_pc0", pc_p1, 16'h0002);
        tick();
        check("t1_inst1", inst_ifid_p2, 16'hA81F);
        check("t1_pc1", pc_p1, 16'h0004);
        tick();
        check("t1_inst2", inst_ifid_p2, 16'h8810);
        check("t1_pc2", pc_p1, 16'h0006);
        check("t1_valid2", 16'(inst_valid_ifid_p2), 16'h1);

        // Jump to 0x40: two bubbles then the target.
        jmp_displacement_idif_p3       = 1'b1;
        jmp_displacement_value_idif_p3 = 16'h0040;
        tick();
        jmp_displacement_idif_p3 = 1'b0;
        check("t2_addr", imem_addr_p1, 16'h0040);
        check("t2_bubble1", 16'(inst_valid_ifid_p2), 16'h0);
        tick();
        check("t2_bubble2", 16'(inst_valid_ifid_p2), 16'h0);
        tick();
        check("t2_valid", 16'(inst_valid_ifid_p2), 16'h1);
        check("t2_inst", inst_ifid_p2, 16'h6020);
        check("t2_pc", pc_p1, 16'h0042);

        // Illegal op at 0x10, then RTI back to 0x12.
        jmp_displacement_idif_p3       = 1'b1;
        jmp_displacement_value_idif_p3 = 16'h0010;
        tick();
        jmp_displacement_idif_p3 = 1'b0;
        wait_valid("t3a");
        check("t3_inst10", inst_ifid_p2, 16'h6008);
        check("t3_pc10", pc_p1, 16'h0012);
        illegal_op_idif_p3 = 1'b1;
        tick();
        illegal_op_idif_p3 = 1'b0;
        check("t3_epc", epc_p1, 16'h0012);
        check("t3_exc_addr", imem_addr_p1, 16'h0002);
        wait_valid("t3b");
        check("t3_exc_inst", inst_ifid_p2, 16'hA81F);
        check("t3_exc_pc", pc_p1, 16'h0004);
        return_execution_idif_p3 = 1'b1;
        tick();
        return_execution_idif_p3 = 1'b0;
        check("t3_rti_addr", imem_addr_p1, 16'h0012);
        wait_valid("t3c");
        check("t3_rti_inst", inst_ifid_p2, 16'h6009);
        check("t3_rti_pc", pc_p1, 16'h0014);

        // Three-cycle stall on the instruction at 0x14.
        tick();
        check("t4_inst14", inst_ifid_p2, 16'h600A);
        stall_idif_p3 = 1'b1;
        tick();
        check("t4_hold_inst_a", inst_ifid_p2, 16'h600A);
        check("t4_hold_pc_a", pc_p1, 16'h0016);
        check("t4_req_a", 16'(imem_req_p1), 16'h0);
        tick();
        check("t4_hold_inst_b", inst_ifid_p2, 16'h600A);
        check("t4_req_b", 16'(imem_req_p1), 16'h0);
        tick();
        stall_idif_p3 = 1'b0;
        tick();
        check("t4_skid_inst", inst_ifid_p2, 16'h600B);
        check("t4_skid_pc", pc_p1, 16'h0018);
        tick();
        wait_valid("t4");
        check("t4_resume_inst", inst_ifid_p2, 16'h600C);
        check("t4_resume_pc", pc_p1, 16'h001A);

        // Halt, then asynchronous reset mid-cycle.
        halt_idif_p3 = 1'b1;
        tick();
        halt_idif_p3 = 1'b0;
        repeat (4) begin
            check("t5_req", 16'(imem_req_p1), 16'h0);
            check("t5_inst", inst_ifid_p2, 16'h0800);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_epc", epc_p1, 16'h0000);
        check("t5_rst_pc", pc_p1, 16'h0000);
        check("t5_rst_addr", imem_addr_p1, 16'h0000);
        @(posedge clk);
        #1;
        rst = 1'b1;
        wait_valid("t5");
        check("t5_restart_inst", inst_ifid_p2, 16'h481F);
        check("t5_restart_pc", pc_p1, 16'h0002);

        // PC wrap at the top of the address space.
        jmp_displacement_idif_p3       = 1'b1;
        jmp_displacement_value_idif_p3 = 16'hFFFC;
        tick();
        jmp_displacement_idif_p3 = 1'b0;
        check("t6_addr_fffc", imem_addr_p1, 16'hFFFC);
        tick();
        check("t6_addr_fffe", imem_addr_p1, 16'hFFFE);
        tick();
        check("t6_addr_wrap", imem_addr_p1, 16'h0000);
        wait_valid("t6a");
        check("t6_inst_fffc", inst_ifid_p2, 16'h6FFE);
        check("t6_pc_fffc", pc_p1, 16'hFFFE);
        tick();
        check("t6_inst_fffe", inst_ifid_p2, 16'h6FFF);
        check("t6_pc_fffe", pc_p1, 16'h0000);
        tick();
        check("t6_inst_0", inst_ifid_p2, 16'h481F);
        check("t6_pc_0", pc_p1, 16'h0002);

        // Stall fills the skid buffer, then a jump arrives under stall.
        stall_idif_p3 = 1'b1;
        tick();
        jmp_displacement_idif_p3       = 1'b1;
        jmp_displacement_value_idif_p3 = 16'h0080;
        tick();
        jmp_displacement_idif_p3 = 1'b0;
        check("t6_sj_bubble1", 16'(inst_valid_ifid_p2), 16'h0);
        tick();
        stall_idif_p3 = 1'b0;
        check("t6_sj_bubble2", 16'(inst_valid_ifid_p2), 16'h0);
        tick();
        check("t6_sj_valid", 16'(inst_valid_ifid_p2), 16'h1);
        check("t6_sj_inst", inst_ifid_p2, 16'h6040);
        check("t6_sj_pc", pc_p1, 16'h0082);
        tick();
        check("t6_sj_next_inst", inst_ifid_p2, 16'h6041);
        check("t6_sj_next_pc", pc_p1, 16'h0084);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage of the uRISC 16-bit pipeline. It sits directly upstream of decode.
- Owns the PC and the synchronous instruction-memory port, and drives the IF/ID pipeline register (inst_ifid_p2) plus pc_p1/epc_p1 into decode.
- Consumes decode's redirect and control outputs: halt, illegal op, return from exception, jump target. Also consumes decode's stall.

Parameters:
- RESET_PC, 16'h0000, PC value loaded at reset.
- EXC_VECTOR, 16'h0002, fetch target taken on an illegal opcode.
- INST_BYTES, 2, PC increment per sequential instruction.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-low (0 = reset)
- imem_addr_p1  out  16  instruction-memory address (current fetch PC)
- imem_req_p1  out  1  memory read request
- imem_rdata_p2  in  16  read data; valid the cycle after the request
- pc_p1  out  16  PC of the instruction currently in IF/ID, plus 2
- epc_p1  out  16  saved exception return PC
- inst_ifid_p2  out  16  instruction to decode; NOP when invalid
- inst_valid_ifid_p2  out  1  IF/ID holds a real instruction
- stall_idif_p3  in  1  decode cannot accept; hold IF/ID
- halt_idif_p3  in  1  decode saw HALT
- illegal_op_idif_p3  in  1  decode saw an illegal opcode
- return_execution_idif_p3  in  1  decode saw RTI
- jmp_displacement_idif_p3  in  1  decode-resolved jump
- jmp_displacement_value_idif_p3  in  16  absolute jump target

Behaviour:
Reset (rst=0, asynchronous):
- fetch_pc=RESET_PC, pc_p1=RESET_PC, epc_p1=0.
- inst_ifid_p2=16'h0800 (NOP), inst_valid_ifid_p2=0, imem_req_p1=0.
- state=RUN, skid buffer empty.
- The first request is issued the first cycle after reset deasserts.

States:
- RUN: request fetch_pc each cycle.
- BUBBLE: one cycle following a redirect. The in-flight wrong-path data is dropped and IF/ID is NOP/invalid. Always → RUN.
- HALTED: imem_req_p1=0, IF/ID is NOP/invalid, terminal until reset.

Latency:
- Address at cycle N, data at N+1, latched into IF/ID at the end of N+1.
- A redirect costs exactly 2 bubbles: the squashed in-flight instruction and the BUBBLE cycle.

Redirect priority (highest first), evaluated only when inst_valid_ifid_p2=1:
1. halt → HALTED.
2. illegal_op → epc_p1 <= pc_p1, fetch_pc <= EXC_VECTOR, → BUBBLE.
3. return_execution → fetch_pc <= epc_p1, → BUBBLE.
4. jmp_displacement → fetch_pc <= jmp_displacement_value, → BUBBLE.

Redirect vs stall:
- Any redirect overrides stall_idif_p3.
- The skid buffer is flushed on redirect.

Sequential and stall rules:
- Sequential fetch: fetch_pc += INST_BYTES. It wraps modulo 2^16 (16'hFFFE → 16'h0000) with no flag.
- Stall (no redirect): IF/ID, pc_p1 and fetch_pc hold. Memory data returning in a stall cycle goes into a 1-entry skid buffer.
- While the skid buffer is full, imem_req_p1=0.
- On stall release: IF/ID loads from the skid buffer first, then the request resumes at the held fetch_pc. No instruction is lost or duplicated.
- pc_p1 always travels with its instruction (PC+2 of that instruction).
- If stall and an in-flight squash coincide, the squash wins and the skid buffer stays empty.
- Asynchronous reset mid-stall or mid-BUBBLE returns all state to its reset values immediately.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs fetch_cnt_o[31:0] (increments per valid instruction loaded into IF/ID) and bubble_cnt_o[31:0] (increments per cycle with inst_valid_ifid_p2=0 outside HALTED).
- Both counters saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- urisc_pkg holds:
  - NOP_INST=16'h0800, HALT_INST=16'h0000;
  - default EXC_VECTOR;
  - typedef enum logic [1:0] fetch_state_t {RUN, BUBBLE, HALTED};
  - typedef struct fetch_entry_t {inst, pc_p1, valid}.
- Sub-module fetch_skid_buf: 1-entry buffer of fetch_entry_t with push/pop/flush and a full flag.

Test Plan:
1. Reset release, memory returns 16'h481F, 16'hA81F, 16'h8810 → IF/ID shows them on consecutive cycles, pc_p1 = 2, 4, 6, inst_valid=1.
2. Jump: jmp_displacement=1, value=16'h0040 while IF/ID is valid → imem_addr_p1=16'h0040 next cycle, 2 NOP/invalid cycles, then the instruction at 0x40 with pc_p1=16'h0042.
3. Illegal op at PC 16'h0010 (pc_p1=16'h0012) → epc_p1=16'h0012, fetch at 16'h0002. A later RTI refetches from 16'h0012.
4. stall_idif_p3 held 3 cycles mid-stream → IF/ID and pc_p1 frozen, imem_req_p1 drops once the skid buffer is full. After release the sequence continues with no gap, duplicate or loss.
5. HALT (halt_idif_p3=1) → imem_req_p1=0 and inst_ifid_p2=16'h0800 forever. Pulling rst low resumes fetch at RESET_PC after release.
6. fetch_pc=16'hFFFE sequential → next imem_addr_p1=16'h0000. Stall and jump in the same cycle → jump taken, skid buffer flushed.
